// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - memory-mapped 8N1 UART transmitter on the Ibex data bus
//
// Purpose: bus responder (req/gnt/rvalid) holding a small TX FIFO drained by an
// 8N1 serializer at a programmable clocks-per-bit period.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i, gnt_o           bus request / combinational grant
//   we_i, be_i, addr_i     write enable, byte enables, byte address ([3:2] decoded)
//   wdata_i                write data
//   rvalid_o, rdata_o      registered response valid / read data
//   err_o                  registered error response (unmapped address)
//   tx_o                   serial output, idle high
module bus_uart_tx #(
  parameter int unsigned FifoDepth   = 4,
  parameter logic [15:0] ClkDivReset = 16'd434
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [7:0]   r_mem [FifoDepth];
  logic [15:0]  r_div;
  logic [15:0]  r_baud;
  logic [2:0]   r_bit;
  logic [7:0]   r_shift;
  state_e       r_state;
  logic         r_tx;
  logic         r_rvalid;
  logic         r_err;
  logic [31:0]  r_rdata;

  logic [1:0]   w_addr;
  logic         w_full;
  logic         w_empty;
  logic         w_busy;
  logic         w_push_req;
  logic         w_push;
  logic         w_pop;
  logic         w_baud_done;
  logic [15:0]  w_reload;
  logic [7:0]   w_rd_byte;
  logic         w_unused;

  assign w_addr  = addr_i[3:2];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_busy  = (r_state != S_IDLE);

  // Only a byte-carrying TXDATA write can be back-pressured; everything else is granted.
  assign w_push_req = req_i & we_i & (w_addr == 2'd0) & be_i[0];
  assign gnt_o      = req_i & ~(w_push_req & w_full);
  assign w_push     = gnt_o & w_push_req;

  // Counter counts down to zero, so a period of N loads N-1; DIV=0 acts like DIV=1.
  assign w_reload    = (r_div == 16'd0) ? 16'd0 : r_div - 16'd1;
  assign w_baud_done = (r_baud == 16'd0);

  // Pops happen from IDLE or at the end of STOP, giving gapless back-to-back frames.
  assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_baud_done));
  assign w_rd_byte = r_mem[r_rptr[AW-1:0]];

  assign w_unused = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= wdata_i[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  // Bus response and DIV register. STATUS samples pre-edge state, so a read
  // coinciding with a push reports the FIFO as it was before the push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
      r_div    <= ClkDivReset;
    end else begin
      r_rvalid <= gnt_o;
      r_err    <= gnt_o & (w_addr == 2'd3);
      r_rdata  <= 32'd0;
      if (gnt_o && !we_i) begin
        case (w_addr)
          2'd1:    r_rdata <= {29'd0, w_busy, w_empty, w_full};
          2'd2:    r_rdata <= {16'd0, r_div};
          default: r_rdata <= 32'd0;
        endcase
      end
      if (gnt_o && we_i && (w_addr == 2'd2)) begin
        if (be_i[0]) r_div[7:0]  <= wdata_i[7:0];
        if (be_i[1]) r_div[15:8] <= wdata_i[15:8];
      end
    end
  end

  // Serializer. r_div is sampled only at reload, so a DIV write never
  // stretches or cuts the bit currently on the line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_rd_byte;
            r_baud  <= w_reload;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_tx    <= r_shift[0];
            r_bit   <= 3'd0;
            r_baud  <= w_reload;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= w_reload;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            if (w_pop) begin
              r_shift <= w_rd_byte;
              r_baud  <= w_reload;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;
  assign tx_o     = r_tx;

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb/tb_bus_uart_tx.sv - self-checking bench for bus_uart_tx
module tb_bus_uart_tx;
  localparam int FifoDepth = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = 4'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        tx_o;

  always #5 clk_i = ~clk_i;

  bus_uart_tx #(.FifoDepth(FifoDepth), .ClkDivReset(16'd434)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .we_i(we_i), .be_i(be_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .err_o(err_o), .tx_o(tx_o)
  );

  int n_pass = 0;
  int n_total = 0;

  logic       cap_en = 1'b0;
  logic       cap_q[$];
  logic [7:0] tx_bytes[$];
  logic [7:0] sent[$];

  // Line sampler, 2 time units after each rising edge.
  always @(posedge clk_i) begin
    #2;
    if (cap_en) cap_q.push_back(tx_o);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bus_rw(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int cnt;
    cnt = 0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    #1;
    while (!gnt_o && cnt < 5000) begin
      @(negedge clk_i); #1; cnt++;
    end
    if (cnt >= 5000) chk("gnt_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
    chk("rvalid_hi", 32'(rvalid_o), 32'd1);
    rd = rdata_o;
    er = err_o;
    req_i = 1'b0; we_i = 1'b0; be_i = 4'd0;
    @(negedge clk_i);
    chk("rvalid_lo", 32'(rvalid_o), 32'd0);
  endtask

  task automatic cap_start();
    @(negedge clk_i);
    cap_q.delete();
    sent.delete();
    cap_en = 1'b1;
  endtask

  // Back-to-back TXDATA writes with Ibex-style held request; called at a negedge.
  task automatic push_bytes(output int stalls);
    stalls = 0;
    foreach (tx_bytes[i]) begin
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; be_i = 4'b0001;
      wdata_i = {24'h0, tx_bytes[i]};
      #1;
      while (!gnt_o && stalls < 5000) begin
        @(negedge clk_i); #1; stalls++;
      end
      if (stalls >= 5000) begin
        chk("push_timeout", 32'd0, 32'd1);
        break;
      end
      sent.push_back(tx_bytes[i]);
      @(negedge clk_i);
    end
    req_i = 1'b0; we_i = 1'b0; be_i = 4'd0;
  endtask

  // Reference line: one idle sample (pop happens the edge after the grant),
  // then contiguous 8N1 frames of 10 bit periods each, then idle.
  task automatic check_wave(input string name, input int div);
    logic exp_q[$];
    int len;
    int cyc;
    int nmis;
    exp_q.push_back(1'b1);
    foreach (sent[k]) begin
      for (int b = 0; b < 10; b++) begin
        logic v;
        if (b == 0) v = 1'b0;
        else if (b == 9) v = 1'b1;
        else v = sent[k][b-1];
        repeat (div) exp_q.push_back(v);
      end
    end
    repeat (4) exp_q.push_back(1'b1);
    len = exp_q.size();
    cyc = 0;
    while (cap_q.size() < len && cyc < 20000) begin
      @(negedge clk_i); cyc++;
    end
    cap_en = 1'b0;
    chk({name, "_len"}, 32'(cap_q.size() >= len), 32'd1);
    nmis = 0;
    for (int i = 0; i < len && i < cap_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) nmis++;
    chk({name, "_wave_mismatches"}, 32'(nmis), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          stalls;
    int          nz;

    repeat (3) @(negedge clk_i);
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_ni = 1'b1;

    vecs.push_back('{1'b0, 32'h4,  4'b0000, 32'h0,        32'h2,   1'b0});
    vecs.push_back('{1'b0, 32'h8,  4'b0000, 32'h0,        32'h1B2, 1'b0});
    vecs.push_back('{1'b1, 32'h8,  4'b0011, 32'h3,        32'h0,   1'b0});
    vecs.push_back('{1'b0, 32'h8,  4'b0000, 32'h0,        32'h3,   1'b0});
    vecs.push_back('{1'b0, 32'h0,  4'b0000, 32'h0,        32'h0,   1'b0});
    vecs.push_back('{1'b0, 32'hC,  4'b0000, 32'h0,        32'h0,   1'b1});
    vecs.push_back('{1'b1, 32'hC,  4'b1111, 32'hFFFFFFFF, 32'h0,   1'b1});
    vecs.push_back('{1'b0, 32'h8,  4'b0000, 32'h0,        32'h3,   1'b0});
    vecs.push_back('{1'b1, 32'h4,  4'b1111, 32'hFFFFFFFF, 32'h0,   1'b0});
    vecs.push_back('{1'b0, 32'h4,  4'b0000, 32'h0,        32'h2,   1'b0});
    vecs.push_back('{1'b1, 32'h0,  4'b0010, 32'h41,       32'h0,   1'b0});
    vecs.push_back('{1'b0, 32'h4,  4'b0000, 32'h0,        32'h2,   1'b0});
    vecs.push_back('{1'b1, 32'h8,  4'b0001, 32'h00ABCD12, 32'h0,   1'b0});
    vecs.push_back('{1'b0, 32'h8,  4'b0000, 32'h0,        32'h12,  1'b0});
    vecs.push_back('{1'b1, 32'h8,  4'b0010, 32'h00000500, 32'h0,   1'b0});
    vecs.push_back('{1'b0, 32'h8,  4'b0000, 32'h0,        32'h512, 1'b0});
    vecs.push_back('{1'b1, 32'h8,  4'b0011, 32'h12340004, 32'h0,   1'b0});
    vecs.push_back('{1'b0, 32'h8,  4'b0000, 32'h0,        32'h4,   1'b0});
    vecs.push_back('{1'b0, 32'h14, 4'b0000, 32'h0,        32'h2,   1'b0});

    foreach (vecs[i]) begin
      bus_rw(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // 0x55 at DIV=4
    tx_bytes = '{8'h55};
    cap_start();
    push_bytes(stalls);
    check_wave("byte55_div4", 4);

    // 0xA5 at DIV=3
    bus_rw(1'b1, 32'h8, 4'b0011, 32'h3, rd, er);
    bus_rw(1'b0, 32'h8, 4'b0000, 32'h0, rd, er);
    chk("div3_read", rd, 32'h3);
    tx_bytes = '{8'hA5};
    cap_start();
    push_bytes(stalls);
    check_wave("byteA5_div3", 3);

    // FIFO fill and stall at DIV=2
    bus_rw(1'b1, 32'h8, 4'b0011, 32'h2, rd, er);
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    cap_start();
    push_bytes(stalls);
    chk("fill_no_stall", 32'(stalls), 32'd0);
    bus_rw(1'b0, 32'h4, 4'b0000, 32'h0, rd, er);
    chk("status_full_busy", rd, 32'h5);
    tx_bytes = '{8'h66};
    push_bytes(stalls);
    chk("stall_seen", 32'(stalls > 0), 32'd1);
    check_wave("stall_div2", 2);
    bus_rw(1'b0, 32'h4, 4'b0000, 32'h0, rd, er);
    chk("status_after_stall", rd, 32'h2);

    // Random bursts against the reference line model
    for (int it = 0; it < 6; it++) begin
      int dv;
      int eff;
      int n;
      dv  = $urandom_range(0, 4);
      eff = (dv == 0) ? 1 : dv;
      n   = $urandom_range(1, FifoDepth + 3);
      bus_rw(1'b1, 32'h8, 4'b0011, 32'(dv), rd, er);
      bus_rw(1'b0, 32'h8, 4'b0000, 32'h0, rd, er);
      chk($sformatf("rnd%0d_div", it), rd, 32'(dv));
      tx_bytes.delete();
      for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
      cap_start();
      push_bytes(stalls);
      check_wave($sformatf("rnd%0d", it), eff);
      bus_rw(1'b0, 32'h4, 4'b0000, 32'h0, rd, er);
      chk($sformatf("rnd%0d_status", it), rd, 32'h2);
    end

    // Reset during DATA with bytes still queued
    bus_rw(1'b1, 32'h8, 4'b0011, 32'h4, rd, er);
    tx_bytes = '{8'h00, 8'h00, 8'h00};
    @(negedge clk_i);
    push_bytes(stalls);
    repeat (10) @(negedge clk_i);
    chk("pre_rst_tx_low", 32'(tx_o), 32'd0);
    #1 rst_ni = 1'b0;
    #1 chk("rst_async_tx", 32'(tx_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus_rw(1'b0, 32'h4, 4'b0000, 32'h0, rd, er);
    chk("post_rst_status", rd, 32'h2);
    bus_rw(1'b0, 32'h8, 4'b0000, 32'h0, rd, er);
    chk("post_rst_div", rd, 32'h1B2);
    cap_start();
    repeat (30) @(negedge clk_i);
    cap_en = 1'b0;
    nz = 0;
    foreach (cap_q[i]) if (cap_q[i] !== 1'b1) nz++;
    chk("post_rst_idle_len", 32'(cap_q.size() >= 28), 32'd1);
    chk("post_rst_idle_line", 32'(nz), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_uart_tx.md
# bus_uart_tx

Memory-mapped UART transmitter that acts as a responder on the Ibex data-bus protocol (req/gnt/rvalid) alongside the SRAM. Software writes bytes into a small TX FIFO; an 8N1 serializer drains the FIFO onto a single serial output at a programmable bit period. It replaces ad-hoc status pins as the SoC's debug and console output.

## Interface

Parameters:
- FifoDepth, 4, TX FIFO entries; power of two, at least 2.
- ClkDivReset, 16'd434, reset value of the DIV register, in clocks per bit.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- req_i  in  1  bus request.
- gnt_o  out  1  bus grant (combinational).
- rvalid_o  out  1  response valid, one cycle after grant.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address; only addr_i[3:2] is decoded.
- wdata_i  in  32  write data.
- rdata_o  out  32  read data, valid with rvalid_o.
- err_o  out  1  error response, valid with rvalid_o.
- tx_o  out  1  serial output, idle high.

## Operation

Register map (addr_i[3:2]):
- 0 TXDATA
  - Write with be_i[0]=1 pushes wdata_i[7:0] into the FIFO.
  - Write with be_i[0]=0 is accepted, no push.
  - Reads return 0.
- 1 STATUS (read-only)
  - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), other bits 0.
  - Writes are ignored, no error.
- 2 DIV
  - bits[15:0] hold clocks per bit; writable under be_i[1:0].
  - Reads return the value zero-extended.
  - A value of 0 behaves as 1.
- 3 unmapped
  - Access is granted; response has err_o=1 and rdata_o=0.
  - No side effects.

Bus handshake:
- gnt_o = req_i, except for a TXDATA write with be_i[0]=1 while the FIFO is full: gnt_o=0 until space frees.
- Ibex holds the request, so it stalls rather than loses data.
- rvalid_o is asserted for exactly one cycle after each granted request, reads and writes alike.
- rdata_o and err_o are registered. rdata_o is 0 for writes.

FIFO:
- Circular buffer with log2(FifoDepth)+1-bit read and write pointers.
- full = pointers differ only in the MSB; empty = pointers equal.
- A push and a pop in the same cycle are both performed.
- A push is never attempted when full, because gnt_o is 0.

Serializer FSM:
- States IDLE, START, DATA, STOP.
- Bit counter is 3 bits; baud counter is 16 bits.
- IDLE: if the FIFO is not empty, pop into the shift register, go to START, tx_o=0.
- START: hold for DIV cycles, then DATA with bit 0.
- DATA: each bit held DIV cycles, LSB first; after bit 7, go to STOP with tx_o=1.
- STOP: hold DIV cycles. Then, if the FIFO is not empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- A DIV write takes effect at the next bit-period reload. The bit in progress keeps its length.

## Timing

Reset values:
- tx_o=1, rvalid_o=0, rdata_o=0, err_o=0.
- FIFO empty, FSM IDLE, DIV=ClkDivReset.

Latencies:
- Granted at edge E0: rvalid_o is high for the cycle after E0.
- A pushed byte is visible in the FIFO after E0.
- The FSM pops at E1 (if IDLE), and tx_o falls after E1.
- Frame length is exactly 10*DIV cycles. Back-to-back frames are contiguous.

STATUS timing:
- STATUS reflects state at the grant edge.
- A read granted in the same cycle as a push reports the pre-push state.

Reset mid-frame:
- tx_o returns to 1 immediately (asynchronous).
- FIFO contents are discarded. No partial frame resumes.

## Test plan

- After reset, with DIV=4, write TXDATA=0x55 -> gnt_o same cycle, rvalid_o next cycle, tx_o low 2 cycles after grant. Then 4-cycle bits 1,0,1,0,1,0,1,0, then stop high. Total 40 cycles.
- Write DIV=0x0003, read DIV -> rdata_o=0x00000003. Send 0xA5 -> each bit lasts 3 cycles, serialized LSB-first as 1,0,1,0,0,1,0,1.
- Write FifoDepth+2 bytes back-to-back at DIV=2:
  - gnt_o drops on the write after the FIFO is full.
  - It re-asserts when the first pop frees an entry.
  - All bytes appear in order with no gaps between frames.
  - STATUS shows full=1 while stalled.
- Idle status and error path:
  - Read STATUS while idle and empty -> 0x00000002.
  - Read and write addr 0xC -> err_o=1, rdata_o=0, no state change.
- Reset mid-frame: assert rst_ni low during DATA -> tx_o=1 immediately; after release, STATUS=0x2 and the line stays idle.
- Ignored writes:
  - Write TXDATA with be_i=4'b0010 -> granted, no push, STATUS still empty.
  - Write STATUS -> no effect.
